tap_loader: RTL
===============

# tap_loader

Coefficient-buffer writer for the NLFSR feedback tap selector. It accepts a framed byte stream of tap indices over a valid/ready handshake and range-checks each index. It assembles the indices in a shadow buffer and commits them atomically onto the packed `co_buf` bus that the tap-selection/XOR block consumes. On every successful commit it pulses a restart request so the NLFSR and tap registers resynchronise to the new polynomial.

## Interface
- `NUM_OF_TAPS`, 15, number of 8-bit tap indices per frame (≥1)
- `MAX_IDX`, 8'h0f, largest legal tap index (register width − 1)
- `clk`  in  1  single clock, all logic on rising edge
- `res`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to open a new load frame
- `byte_in`  in  8  tap index byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `co_buf`  out  NUM_OF_TAPS*8  committed indices; tap i at `co_buf[i*8-1 -: 8]`
- `co_valid`  out  1  `co_buf` holds a committed frame
- `busy`  out  1  frame open (LOAD or COMMIT)
- `done`  out  1  one-cycle pulse: commit succeeded
- `load_err`  out  1  sticky: last frame rejected
- `nlfsr_res`  out  1  one-cycle restart request to NLFSR/tap logic, coincident with `done`

## Operation
- FSM states: IDLE, LOAD, COMMIT.
- IDLE: `byte_ready`=0; bytes ignored. `start` → LOAD, byte counter cleared, error flag cleared, `load_err` cleared.
- LOAD: `byte_ready`=1. Transfer = `byte_valid & byte_ready`. The k-th accepted byte (k=0..NUM_OF_TAPS−1) is written to shadow tap NUM_OF_TAPS−k, so the first byte lands in the top byte of `co_buf`.
- Range check per accepted byte: `byte_in > MAX_IDX` sets the frame error flag. Loading continues to the full count; the frame is rejected at commit.
- The last accepted byte (k=NUM_OF_TAPS−1) moves the FSM → COMMIT.
- COMMIT (exactly one cycle, `byte_ready`=0):
  - No error: `co_buf` ← shadow, `co_valid` ← 1, `done` and `nlfsr_res` pulse.
  - Error: `co_buf` and `co_valid` unchanged, `load_err` ← 1, no pulses.
  - Either case → IDLE.
- `start` during LOAD aborts the frame: counter and error flag are cleared, shadow contents are don't-care, and the FSM stays in LOAD. A byte presented in the same cycle as that `start` is accepted as byte 0 of the new frame.
- `start` during COMMIT is ignored.
- Counter width is $clog2(NUM_OF_TAPS+1). There is no wrap; the COMMIT transition precedes overflow.

## Timing
- Reset values: `co_buf` all zero, `co_valid`=0, `busy`=0, `done`=0, `load_err`=0, `nlfsr_res`=0, `byte_ready`=0, state IDLE.
- `res` mid-frame discards the frame and returns all outputs to their reset values on the next edge. `res` dominates `start`.
- `byte_ready`, `busy` and `co_buf` are registered-state decodes with no combinational path from inputs.
- Latency:
  - `start` at edge S → `byte_ready`=1 from cycle S+1.
  - Last byte accepted at edge N → COMMIT during cycle N..N+1.
  - `co_buf`/`co_valid` update at edge N+1.
  - `done`/`nlfsr_res` high for cycle N+1..N+2.
  - Back-to-back frame: `start` is accepted in the cycle after COMMIT.
- Minimum frame duration: NUM_OF_TAPS+2 cycles from `start` to `done`.

## Structure
- Shared package holds:
  - `TAP_W` = 8
  - default `MAX_IDX`
  - the state enum {IDLE, LOAD, COMMIT}
  - the byte-slice helper used by both this block and the tap selector (tap i ↔ bits i*8-1 : i*8-8)
- Single module with no sub-module. The shadow buffer and committed buffer are two packed registers of NUM_OF_TAPS*8 bits.

## Test plan
- Reset, then `start` and 15 bytes 0x0f..0x01 with `byte_valid` held high → `co_buf` = 0x0f0e0d…01. Top byte 0x0f. `co_valid`=1. `done`/`nlfsr_res` high for exactly one cycle, 17 cycles after `start`.
- Same frame with `byte_valid` toggled 1/0 each cycle → identical `co_buf`. `done` arrives 14 cycles later than in the gapless case.
- Commit a good frame, then send a frame whose 5th byte is 0x10 → `load_err`=1 after the 15th byte. `co_buf` keeps the previous value. No `done`.
- `start` again after 7 bytes, then 15 bytes of 0x03 → `co_buf` = 15×0x03 and `load_err`=0.
- Assert `res` at byte 9 of a frame → next cycle all outputs at reset values. A following full frame commits normally.
- `byte_valid` high in IDLE with no `start` → `byte_ready`=0 and `co_buf` unchanged.

Source files
------------

// File: rtl/tap_loader_pkg.sv
// tap_loader_pkg: shared widths, defaults, FSM states and tap byte-slice helper
// Used by tap_loader and by the tap selector that consumes the committed buffer.
package tap_loader_pkg;
   localparam int TAP_W = 8;
   localparam logic [TAP_W-1:0] DEF_MAX_IDX = 8'h0f;
   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
   // tap i (1-based) occupies bits i*TAP_W-1 : i*TAP_W-TAP_W
   function automatic int tap_lsb(input int i);
      return i * TAP_W - TAP_W;
   endfunction
endpackage

// File: rtl/tap_loader_if.sv
// tap_loader_if: framed tap-index byte stream with valid/ready handshake
// Ports: start (open frame), byte_in/byte_valid (data), byte_ready (accept).
import tap_loader_pkg::*;
interface tap_loader_if;
   logic             start;
   logic [TAP_W-1:0] byte_in;
   logic             byte_valid;
   logic             byte_ready;
   modport master (output start, byte_in, byte_valid, input byte_ready);
   modport slave  (input start, byte_in, byte_valid, output byte_ready);
endinterface

// File: rtl/tap_loader.sv
// tap_loader: range-checks a frame of tap indices and commits it atomically
// Ports: i_clk/i_res (sync active-high), bus (byte stream slave),
// o_co_buf/o_co_valid (committed taps), o_busy, o_done, o_load_err, o_nlfsr_res.
import tap_loader_pkg::*;
module tap_loader #(
   parameter int               NUM_OF_TAPS = 15,
   parameter logic [TAP_W-1:0] MAX_IDX     = DEF_MAX_IDX
) (
   input  logic                         i_clk,
   input  logic                         i_res,
   tap_loader_if.slave                  bus,
   output logic [NUM_OF_TAPS*TAP_W-1:0] o_co_buf,
   output logic                         o_co_valid,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_load_err,
   output logic                         o_nlfsr_res
);
   localparam int CW = $clog2(NUM_OF_TAPS + 1);
   state_t                       r_state, w_next;
   logic [CW-1:0]                r_cnt, w_k;
   logic                         r_err, r_done, r_co_valid, r_load_err;
   logic [NUM_OF_TAPS*TAP_W-1:0] r_shadow, r_co_buf;
   logic                         w_ready, w_busy, w_xfer, w_last, w_bad;
   always_ff @(posedge i_clk)
      if (i_res) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb
      w_next = (r_state == IDLE) ? (bus.start ? LOAD : IDLE) :
               (r_state == LOAD) ? (w_last ? COMMIT : LOAD) : IDLE;
   // start inside LOAD restarts the frame, so its byte becomes index 0
   always_comb begin
      w_ready = r_state == LOAD;
      w_busy  = r_state != IDLE;
      w_xfer  = w_ready & bus.byte_valid;
      w_k     = bus.start ? '0 : r_cnt;
      w_last  = w_xfer & (w_k == CW'(NUM_OF_TAPS - 1));
      w_bad   = bus.byte_in > MAX_IDX;
   end
   always_ff @(posedge i_clk)
      if (i_res) begin
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_shadow   <= '0;
         r_co_buf   <= '0;
         r_co_valid <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_done <= (r_state == COMMIT) & ~r_err;
         if (r_state == IDLE && bus.start) begin
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_load_err <= 1'b0;
         end
         if (w_ready) begin
            r_cnt <= w_xfer ? w_k + CW'(1) : w_k;
            r_err <= (r_err & ~bus.start) | (w_xfer & w_bad);
         end
         // first byte of a frame lands in the top tap
         if (w_xfer)
            r_shadow[tap_lsb(NUM_OF_TAPS - int'(w_k)) +: TAP_W] <= bus.byte_in;
         if (r_state == COMMIT && !r_err) begin
            r_co_buf   <= r_shadow;
            r_co_valid <= 1'b1;
         end
         if (r_state == COMMIT && r_err) r_load_err <= 1'b1;
      end
   assign bus.byte_ready = w_ready;
   assign o_busy         = w_busy;
   assign o_co_buf       = r_co_buf;
   assign o_co_valid     = r_co_valid;
   assign o_done         = r_done;
   assign o_nlfsr_res    = r_done;
   assign o_load_err     = r_load_err;
endmodule
